// File: rtl/servo_ramp_controller.sv
// Multi-channel hobby-servo PWM driver with debounced open/close toggles, host target
// loads and per-frame slew limiting of the pulse width.
module servo_ramp_controller #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CH_W       = 3,
  parameter int unsigned CNT_W      = 21,
  parameter int unsigned PWM_PERIOD = 2_000_000,
  parameter int unsigned PULSE_MIN  = 50_000,
  parameter int unsigned PULSE_MAX  = 250_000,
  parameter int unsigned STEP       = 2_500,
  parameter int unsigned DEB_LEN    = 65_536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] toggle,
  input  logic              tgt_valid,
  input  logic [CH_W-1:0]   tgt_ch,
  input  logic [CNT_W-1:0]  tgt_width,
  output logic              tgt_ready,
  output logic [NUM_CH-1:0] servo,
  output logic [NUM_CH-1:0] pos_open,
  output logic [NUM_CH-1:0] at_target,
  output logic              frame_tick
);

  localparam int unsigned DEB_W = (DEB_LEN > 2) ? $clog2(DEB_LEN) : 1;
  localparam int unsigned EXT_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_W       = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] MAX_W       = CNT_W'(PULSE_MAX);
  localparam logic [CNT_W-1:0] MID_W       = CNT_W'((PULSE_MIN + PULSE_MAX) / 2);
  localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(STEP);
  localparam logic [EXT_W-1:0] STEP_X      = EXT_W'(STEP);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             frame_end;
  logic             host_xfer;
  logic [CNT_W-1:0] clamped;

  // Shared frame counter; the last count is the ramp update point
  always_comb begin
    frame_end = (cnt_q == PERIOD_LAST);
    cnt_d     = frame_end ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    host_xfer = tgt_valid & tgt_ready;
    clamped   = tgt_width;
    if (tgt_width < MIN_W) begin
      clamped = MIN_W;
    end else if (tgt_width > MAX_W) begin
      clamped = MAX_W;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      frame_tick <= 1'b0;
      tgt_ready  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      frame_tick <= frame_end;
      tgt_ready  <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] cur_d;
    logic [CNT_W-1:0] tgt_q;
    logic [CNT_W-1:0] tgt_d;
    logic [DEB_W-1:0] deb_q;
    logic [DEB_W-1:0] deb_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise;
    logic             pos_q;
    logic             pos_d;
    logic             servo_q;
    logic             host_hit;

    assign host_hit = host_xfer && (tgt_ch == CH_W'(g));

    // Accept a new level only after DEB_LEN consecutive differing samples
    always_comb begin
      deb_d    = '0;
      stable_d = stable_q;
      rise     = 1'b0;
      if (toggle[g] != stable_q) begin
        if (deb_q == DEB_LAST) begin
          stable_d = ~stable_q;
          rise     = ~stable_q;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
    end

    // Host load takes priority over a coincident toggle edge
    always_comb begin
      tgt_d = tgt_q;
      pos_d = pos_q;
      if (host_hit) begin
        tgt_d = clamped;
        pos_d = (clamped > MID_W);
      end else if (rise) begin
        pos_d = ~pos_q;
        tgt_d = pos_q ? MIN_W : MAX_W;
      end
    end

    // Slew toward the target once per frame; compares run one bit wider to avoid wrap
    always_comb begin
      cur_d = cur_q;
      if (frame_end) begin
        if (STEP == 0) begin
          cur_d = tgt_q;
        end else if (cur_q < tgt_q) begin
          if (({1'b0, cur_q} + STEP_X) >= {1'b0, tgt_q}) begin
            cur_d = tgt_q;
          end else begin
            cur_d = cur_q + STEP_C;
          end
        end else if (cur_q > tgt_q) begin
          if ({1'b0, cur_q} <= ({1'b0, tgt_q} + STEP_X)) begin
            cur_d = tgt_q;
          end else begin
            cur_d = cur_q - STEP_C;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cur_q    <= MIN_W;
        tgt_q    <= MIN_W;
        deb_q    <= '0;
        stable_q <= 1'b0;
        pos_q    <= 1'b0;
        servo_q  <= 1'b0;
      end else begin
        cur_q    <= cur_d;
        tgt_q    <= tgt_d;
        deb_q    <= deb_d;
        stable_q <= stable_d;
        pos_q    <= pos_d;
        servo_q  <= (cnt_q < cur_q);
      end
    end

    assign servo[g]     = servo_q;
    assign pos_open[g]  = pos_q;
    assign at_target[g] = (cur_q == tgt_q);
  end

endmodule

// File: tb/tb_servo_ramp_controller.sv
// Directed bench for servo_ramp_controller with a short frame and small pulse widths.
module tb_servo_ramp_controller;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned CNT_W  = 21;
  localparam int unsigned PERIOD = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] toggle = '0;
  logic              tgt_valid = 1'b0;
  logic [CH_W-1:0]   tgt_ch = '0;
  logic [CNT_W-1:0]  tgt_width = '0;
  logic              tgt_ready;
  logic [NUM_CH-1:0] servo;
  logic [NUM_CH-1:0] pos_open;
  logic [NUM_CH-1:0] at_target;
  logic              frame_tick;

  int checks = 0;
  int failures = 0;

  servo_ramp_controller #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .PWM_PERIOD(PERIOD),
    .PULSE_MIN(10), .PULSE_MAX(50), .STEP(10), .DEB_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .toggle(toggle), .tgt_valid(tgt_valid),
    .tgt_ch(tgt_ch), .tgt_width(tgt_width), .tgt_ready(tgt_ready),
    .servo(servo), .pos_open(pos_open), .at_target(at_target), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Waits for a frame start, then counts servo high cycles over one full frame
  task automatic measure(output int w0, output int w1, output int first0, output bit ok);
    int n = 0;
    int ticks = 0;
    w0 = 0; w1 = 0; first0 = -1; ok = 1'b1;
    while (frame_tick !== 1'b1 && n < 250) begin
      @(negedge clk);
      n++;
    end
    if (frame_tick !== 1'b1) ok = 1'b0;
    for (int k = 0; k < int'(PERIOD); k++) begin
      if (frame_tick === 1'b1) ticks++;
      if (servo[0] === 1'b1) begin
        w0++;
        if (first0 < 0) first0 = k;
      end
      if (servo[1] === 1'b1) w1++;
      @(negedge clk);
    end
    if (ticks != 1 || frame_tick !== 1'b1) ok = 1'b0;
  endtask

  task automatic host_load(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] w);
    tgt_ch = ch;
    tgt_width = w;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    toggle = '0;
    repeat (3) @(negedge clk);
    checks++; if (servo !== 2'b00) begin failures++; $display("FAIL reset_servo got=%b want=00", servo); end
    checks++; if (pos_open !== 2'b00) begin failures++; $display("FAIL reset_pos_open got=%b want=00", pos_open); end
    checks++; if (at_target !== 2'b11) begin failures++; $display("FAIL reset_at_target got=%b want=11", at_target); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_frame_tick got=%b want=0", frame_tick); end
    checks++; if (tgt_ready !== 1'b0) begin failures++; $display("FAIL reset_tgt_ready got=%b want=0", tgt_ready); end
    reset = 1'b0;
    @(negedge clk);
    n = 1;
    checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b want=1", tgt_ready); end
    while (frame_tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 100) begin failures++; $display("FAIL first_tick_cycles got=%0d want=100", n); end
  endtask

  task automatic test_idle();
    int w0, w1, f0;
    bit ok;
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w0 != 10 || w1 != 10) begin failures++; $display("FAIL idle_width ok=%0b w0=%0d w1=%0d want=10,10", ok, w0, w1); end
    checks++; if (f0 != 1) begin failures++; $display("FAIL idle_pulse_start got=%0d want=1", f0); end
    checks++; if (at_target !== 2'b11) begin failures++; $display("FAIL idle_at_target got=%b want=11", at_target); end
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w0 != 10) begin failures++; $display("FAIL idle_period ok=%0b w0=%0d want=10", ok, w0); end
  endtask

  task automatic test_toggle_ramp();
    int up[4] = '{20, 30, 40, 50};
    int dn[4] = '{40, 30, 20, 10};
    int w0, w1, f0;
    bit ok;
    toggle[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pos_open[0] !== 1'b0) begin failures++; $display("FAIL toggle_early got=%b want=0", pos_open[0]); end
    @(negedge clk);
    checks++; if (pos_open !== 2'b01) begin failures++; $display("FAIL toggle_open got=%b want=01", pos_open); end
    checks++; if (at_target !== 2'b10) begin failures++; $display("FAIL toggle_at_target got=%b want=10", at_target); end
    repeat (2) @(negedge clk);
    toggle[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      measure(w0, w1, f0, ok);
      checks++; if (!ok || w0 != up[j] || w1 != 10) begin failures++; $display("FAIL ramp_up frame=%0d ok=%0b w0=%0d want=%0d w1=%0d", j, ok, w0, up[j], w1); end
    end
    checks++; if (at_target !== 2'b11) begin failures++; $display("FAIL ramp_up_done got=%b want=11", at_target); end
    toggle[0] = 1'b1;
    repeat (6) @(negedge clk);
    toggle[0] = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (pos_open !== 2'b00) begin failures++; $display("FAIL toggle_close got=%b want=00", pos_open); end
    for (int j = 0; j < 4; j++) begin
      measure(w0, w1, f0, ok);
      checks++; if (!ok || w0 != dn[j]) begin failures++; $display("FAIL ramp_down frame=%0d ok=%0b w0=%0d want=%0d", j, ok, w0, dn[j]); end
    end
    checks++; if (at_target !== 2'b11) begin failures++; $display("FAIL ramp_down_done got=%b want=11", at_target); end
  endtask

  task automatic test_glitch();
    int w0, w1, f0;
    bit ok;
    toggle[1] = 1'b1;
    repeat (3) @(negedge clk);
    toggle[1] = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (pos_open !== 2'b00 || at_target !== 2'b11) begin failures++; $display("FAIL glitch_state pos_open=%b at_target=%b want=00,11", pos_open, at_target); end
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w1 != 10) begin failures++; $display("FAIL glitch_width ok=%0b w1=%0d want=10", ok, w1); end
  endtask

  task automatic test_host();
    int up[4] = '{20, 30, 40, 50};
    int w0, w1, f0;
    bit ok;
    host_load(3'd1, 21'd200);
    checks++; if (pos_open !== 2'b10 || at_target !== 2'b01) begin failures++; $display("FAIL host_clamp_hi pos_open=%b at_target=%b want=10,01", pos_open, at_target); end
    host_load(3'd1, 21'd5);
    checks++; if (pos_open !== 2'b00 || at_target !== 2'b11) begin failures++; $display("FAIL host_clamp_lo pos_open=%b at_target=%b want=00,11", pos_open, at_target); end
    checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL host_ready got=%b want=1", tgt_ready); end
    host_load(3'd3, 21'd40);
    checks++; if (pos_open !== 2'b00 || at_target !== 2'b11) begin failures++; $display("FAIL host_bad_ch pos_open=%b at_target=%b want=00,11", pos_open, at_target); end
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w0 != 10 || w1 != 10) begin failures++; $display("FAIL host_bad_ch_width ok=%0b w0=%0d w1=%0d want=10,10", ok, w0, w1); end
    host_load(3'd1, 21'd50);
    for (int j = 0; j < 4; j++) begin
      measure(w0, w1, f0, ok);
      checks++; if (!ok || w1 != up[j] || w0 != 10) begin failures++; $display("FAIL host_ramp frame=%0d ok=%0b w1=%0d want=%0d w0=%0d", j, ok, w1, up[j], w0); end
    end
    host_load(3'd1, 21'd10);
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w1 != 40) begin failures++; $display("FAIL host_down ok=%0b w1=%0d want=40", ok, w1); end
    host_load(3'd1, 21'd30);
    checks++; if (pos_open[1] !== 1'b0) begin failures++; $display("FAIL host_mid_pos got=%b want=0", pos_open[1]); end
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w1 != 30) begin failures++; $display("FAIL host_redirect ok=%0b w1=%0d want=30", ok, w1); end
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w1 != 30 || at_target !== 2'b11) begin failures++; $display("FAIL host_hold ok=%0b w1=%0d at_target=%b want=30,11", ok, w1, at_target); end
  endtask

  task automatic test_back_to_back();
    int w0, w1, f0;
    bit ok;
    toggle = 2'b11;
    repeat (3) @(negedge clk);
    host_load(3'd0, 21'd10);
    checks++; if (pos_open !== 2'b10 || at_target !== 2'b01) begin failures++; $display("FAIL same_cycle pos_open=%b at_target=%b want=10,01", pos_open, at_target); end
    toggle = 2'b00;
    repeat (6) @(negedge clk);
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w0 != 10 || w1 != 40) begin failures++; $display("FAIL same_cycle_width ok=%0b w0=%0d w1=%0d want=10,40", ok, w0, w1); end
  endtask

  task automatic test_reset_mid_ramp();
    int w0, w1, f0, n;
    bit ok;
    toggle[0] = 1'b1;
    repeat (6) @(negedge clk);
    toggle[0] = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (pos_open !== 2'b11) begin failures++; $display("FAIL mid_open got=%b want=11", pos_open); end
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w0 != 20 || w1 != 50) begin failures++; $display("FAIL mid_width ok=%0b w0=%0d w1=%0d want=20,50", ok, w0, w1); end
    repeat (20) @(negedge clk);
    checks++; if (servo !== 2'b11) begin failures++; $display("FAIL mid_servo_high got=%b want=11", servo); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (servo !== 2'b00 || pos_open !== 2'b00) begin failures++; $display("FAIL mid_reset servo=%b pos_open=%b want=00,00", servo, pos_open); end
    checks++; if (at_target !== 2'b11 || tgt_ready !== 1'b0 || frame_tick !== 1'b0) begin failures++; $display("FAIL mid_reset_flags at_target=%b ready=%b tick=%b want=11,0,0", at_target, tgt_ready, frame_tick); end
    reset = 1'b0;
    @(negedge clk);
    n = 1;
    while (frame_tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 100) begin failures++; $display("FAIL mid_restart_cycles got=%0d want=100", n); end
    measure(w0, w1, f0, ok);
    checks++; if (!ok || w0 != 10 || w1 != 10) begin failures++; $display("FAIL mid_restart_width ok=%0b w0=%0d w1=%0d want=10,10", ok, w0, w1); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_toggle_ramp();
    test_glitch();
    test_host();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
